f_fetch_stage: RTL
==================

// Module: f_fetch_stage
// PURPOSE
//  Fetch stage plus F/D pipeline register, directly upstream of the D stage.
//  Holds the PC, selects next-PC (handler/stall/eret/branch/+4), and flags AdEL on the fetch address.
//  Registers {pc, instr, exc_code, bd} into D. D_imm16 feeds the D-stage immediate extender.
// PARAMETERS
//  RESET_PC    32'h0000_3000  PC value after reset
//  HANDLER_PC  32'h0000_4180  exception/interrupt entry
//  IM_BASE     32'h0000_3000  lowest legal fetch address
//  IM_TOP      32'h0000_6ffc  highest legal fetch address, inclusive
// PORTS
//  clk           in   1   system clock, rising edge
//  reset         in   1   synchronous, active-high reset
//  stall         in   1   hazard unit: hold PC and F/D register
//  req           in   1   CP0 exception/interrupt request: redirect to HANDLER_PC, flush F/D
//  D_eret        in   1   eret decoded in D
//  epc           in   32  CP0 EPC, the eret target
//  D_jump        in   1   branch taken or jump in D
//  D_target      in   32  branch/jump target from D
//  D_is_branch   in   1   instr in D is a branch/jump; the instr now in F is its delay slot
//  i_inst_addr   out  32  instruction memory address (= F_pc)
//  i_inst_rdata  in   32  instruction word, combinational read
//  D_pc          out  32  PC of instr in D
//  D_instr       out  32  instr in D
//  D_imm16       out  16  D_instr[15:0], fed to the D-stage extender
//  D_exc_code    out  5   exception code carried with D instr; 0 = none
//  D_bd          out  1   D instr is in a delay slot
// BEHAVIOUR
//  - Reset (sync, beats everything):
//    - F_pc <= RESET_PC.
//    - D_pc <= RESET_PC; D_instr, D_exc_code and D_bd <= 0.
//  - Next-PC priority, evaluated each rising edge:
//    1. req -> HANDLER_PC
//    2. stall -> hold
//    3. D_eret -> epc
//    4. D_jump -> D_target
//    5. otherwise F_pc+4, 32-bit wrap
//  - AdEL: raised when F_pc[1:0]!=0, F_pc<IM_BASE or F_pc>IM_TOP.
//    - F_exc = 5'd4; F_instr forced to 0 (nop) so D never decodes garbage.
//    - Otherwise F_instr = i_inst_rdata and F_exc = 0.
//  - F/D register priority:
//    1. req -> bubble: D_pc <= HANDLER_PC, instr/exc/bd <= 0.
//    2. stall -> hold all D_* outputs.
//    3. D_eret -> bubble (no eret delay slot): D_pc <= F_pc, instr/exc/bd <= 0.
//    4. otherwise load F_pc, F_instr, F_exc, bd <= D_is_branch.
//  - req together with stall: req wins; the stalled D instr is discarded by the flush.
//  - D_eret together with D_jump: eret wins. That combination cannot occur legally.
//  - Latency: an instr fetched at edge n appears on D_* after edge n+1. No combinational path from
//    stall/req to D_*.
//  - i_inst_addr is driven straight from F_pc register; it is valid during reset cycles.
// STRUCTURE
//  - def.v: `EXC_AdEL (5'd4), `EXC_NONE, default RESET_PC and HANDLER_PC macros.
//  - Sub-module f_d_reg: the F/D register with reset/req/stall/flush priority.
//  - PC register, next-PC mux and AdEL check stay in the top.
// TESTING
//  - reset 2 cycles then release, no stalls -> i_inst_addr 3000,3004,3008; D_pc lags one cycle.
//  - stall=1 for 3 cycles at F_pc=300c -> F_pc and all D_* frozen; resume -> 3010 next.
//  - D_is_branch=1, D_jump=1, D_target=3100 at F_pc=3008 -> D_pc=3008 with D_bd=1, then F_pc=3100.
//  - D_target=3002 -> next cycle D_exc_code=4, D_instr=0, D_pc=3002.
//  - D_target=7000 -> same AdEL response, D_pc=7000.
//  - req=1 with stall=1 -> next F_pc=4180, D_instr=0, D_pc=4180, D_bd=0.
//  - D_eret=1, epc=3020 -> F/D bubble with D_pc=old F_pc, then F_pc=3020, fetch continues at 3024.

Source files
------------

// File: rtl/f_fetch_stage_pkg.sv
// Shared types and constants for the fetch stage and its F/D pipeline register.
// Also holds the fetch-address legality check.
package f_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DEF    = 32'h0000_3000;
  localparam logic [31:0] IM_TOP_DEF     = 32'h0000_6ffc;
  localparam logic [31:0] PC_STEP        = 32'd4;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic [2:0] {
    NPC_HANDLER = 3'd0,
    NPC_HOLD    = 3'd1,
    NPC_ERET    = 3'd2,
    NPC_JUMP    = 3'd3,
    NPC_SEQ     = 3'd4
  } npc_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
  } fd_bundle_t;

  // Fetch address is illegal when misaligned or outside [base, top].
  function automatic logic adel_check(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] top);
    return (addr[1:0] != 2'b00) || (addr < base) || (addr > top);
  endfunction

endpackage

// File: rtl/f_d_reg.sv
// F/D pipeline register: reset, then req flush, stall hold, eret bubble, normal load.
// The eret bubble keeps the PC so the fetched-but-dropped instruction is still traceable.
module f_d_reg
  import f_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       req,
  input  logic       eret,
  input  fd_bundle_t f_bundle,
  output fd_bundle_t d_bundle
);

  fd_bundle_t d_r;
  fd_bundle_t d_next_s;

  // Next F/D contents by priority: req, stall, eret, load.
  always_comb begin
    d_next_s = d_r;
    if (req) begin
      d_next_s = '{pc: HANDLER_PC, instr: 32'd0, exc: EXC_NONE, bd: 1'b0};
    end else if (stall) begin
      d_next_s = d_r;
    end else if (eret) begin
      d_next_s = '{pc: f_bundle.pc, instr: 32'd0, exc: EXC_NONE, bd: 1'b0};
    end else begin
      d_next_s = f_bundle;
    end
  end

  // F/D state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_r <= '{pc: RESET_PC, instr: 32'd0, exc: EXC_NONE, bd: 1'b0};
    end else begin
      d_r <= d_next_s;
    end
  end

  assign d_bundle = d_r;

endmodule

// File: rtl/f_fetch_stage.sv
// Fetch stage: PC register, next-PC selection and AdEL check, feeding the F/D register.
// D_* outputs come straight from the F/D register; i_inst_addr straight from the PC register.
module f_fetch_stage
  import f_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter logic [31:0] IM_BASE    = IM_BASE_DEF,
  parameter logic [31:0] IM_TOP     = IM_TOP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        D_eret,
  input  logic [31:0] epc,
  input  logic        D_jump,
  input  logic [31:0] D_target,
  input  logic        D_is_branch,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic [15:0] D_imm16,
  output logic [4:0]  D_exc_code,
  output logic        D_bd
);

  logic [31:0] f_pc_r;
  logic [31:0] npc_s;
  npc_sel_e    npc_sel_s;
  logic        adel_s;
  fd_bundle_t  f_bundle_s;
  fd_bundle_t  d_bundle_s;

  // Next-PC source by priority: req, stall, eret, jump, sequential.
  always_comb begin
    npc_sel_s = NPC_SEQ;
    if (req) begin
      npc_sel_s = NPC_HANDLER;
    end else if (stall) begin
      npc_sel_s = NPC_HOLD;
    end else if (D_eret) begin
      npc_sel_s = NPC_ERET;
    end else if (D_jump) begin
      npc_sel_s = NPC_JUMP;
    end else begin
      npc_sel_s = NPC_SEQ;
    end
  end

  // Next-PC value mux.
  always_comb begin
    npc_s = f_pc_r + PC_STEP;
    case (npc_sel_s)
      NPC_HANDLER: npc_s = HANDLER_PC;
      NPC_HOLD:    npc_s = f_pc_r;
      NPC_ERET:    npc_s = epc;
      NPC_JUMP:    npc_s = D_target;
      NPC_SEQ:     npc_s = f_pc_r + PC_STEP;
      default:     npc_s = f_pc_r + PC_STEP;
    endcase
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_r <= RESET_PC;
    end else begin
      f_pc_r <= npc_s;
    end
  end

  assign adel_s = adel_check(f_pc_r, IM_BASE, IM_TOP);

  // An illegal fetch turns into a nop tagged with AdEL so D never decodes garbage.
  always_comb begin
    f_bundle_s.pc = f_pc_r;
    f_bundle_s.bd = D_is_branch;
    if (adel_s) begin
      f_bundle_s.instr = 32'd0;
      f_bundle_s.exc   = EXC_ADEL;
    end else begin
      f_bundle_s.instr = i_inst_rdata;
      f_bundle_s.exc   = EXC_NONE;
    end
  end

  f_d_reg #(
    .RESET_PC   (RESET_PC),
    .HANDLER_PC (HANDLER_PC)
  ) u_f_d_reg (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .req      (req),
    .eret     (D_eret),
    .f_bundle (f_bundle_s),
    .d_bundle (d_bundle_s)
  );

  assign i_inst_addr = f_pc_r;
  assign D_pc        = d_bundle_s.pc;
  assign D_instr     = d_bundle_s.instr;
  assign D_imm16     = d_bundle_s.instr[15:0];
  assign D_exc_code  = d_bundle_s.exc;
  assign D_bd        = d_bundle_s.bd;

endmodule
